// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmit and receive paths.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int DATA_BITS            = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 10;

endpackage

// File: rtl/uart_transmitter_if.sv
// Byte handshake between an upstream producer (master) and the UART transmitter (slave).
interface uart_transmitter_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] data_in;
  logic                 data_valid;
  logic                 data_ready;

  modport master (output data_in, output data_valid, input data_ready);
  modport slave  (input data_in, input data_valid, output data_ready);

endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with registered read data; pointers carry an extra wrap bit
// so that full and empty are distinguishable without a separate counter.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = DATA_BITS,
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wr_data,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [WIDTH-1:0] rd_data_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign count     = wr_ptr_r - rd_ptr_r;
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;
  assign rd_data   = rd_data_r;

  // Storage, pointers and read-data register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r  <= {(AW+1){1'b0}};
      rd_ptr_r  <= {(AW+1){1'b0}};
      rd_data_r <= {WIDTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
        wr_ptr_r                <= wr_ptr_r + 1'b1;
      end
      if (pop_ok_s) begin
        rd_data_r <= mem_r[rd_ptr_r[AW-1:0]];
        rd_ptr_r  <= rd_ptr_r + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter: queues bytes from a valid/ready handshake and shifts
// them out LSB first, each bit held for CLKS_PER_BIT clocks.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 4,
  parameter int STOP_BITS    = 1
) (
  input  logic                        clock,
  input  logic                        reset_n,
  uart_transmitter_if.slave           tx_if,
  output logic                        serialOut,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int             BW        = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0]  BAUD_ZERO = BW'(0);
  localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]     LAST_BIT  = 3'(DATA_BITS - 1);

  tx_state_t            state_r;
  logic [BW-1:0]        baud_cnt_r;
  logic [2:0]           bit_cnt_r;
  logic [DATA_BITS-1:0] shift_r;
  logic                 serial_r;
  logic                 stop_idx_r;

  logic                 fifo_full_s;
  logic                 fifo_empty_s;
  logic [DATA_BITS-1:0] fifo_rd_s;
  logic                 push_s;
  logic                 pop_s;
  logic                 baud_last_s;
  logic                 stop_last_s;

  assign push_s      = tx_if.data_valid & ~fifo_full_s;
  assign baud_last_s = (baud_cnt_r == BAUD_LAST);
  assign stop_last_s = (state_r == STOP) && baud_last_s && (stop_idx_r == 1'(STOP_BITS - 1));
  assign pop_s       = ~fifo_empty_s && ((state_r == IDLE) || stop_last_s);

  assign tx_if.data_ready = ~fifo_full_s;
  assign serialOut        = serial_r;
  assign busy             = (state_r != IDLE) || ~fifo_empty_s;

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push_s),
    .pop     (pop_s),
    .wr_data (tx_if.data_in),
    .rd_data (fifo_rd_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s),
    .count   (fifo_count)
  );

  // Frame sequencer; serial_r is always loaded with the level of the state being entered.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= IDLE;
      baud_cnt_r <= BAUD_ZERO;
      bit_cnt_r  <= 3'd0;
      shift_r    <= {DATA_BITS{1'b0}};
      serial_r   <= 1'b1;
      stop_idx_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (pop_s) begin
            state_r    <= START;
            baud_cnt_r <= BAUD_ZERO;
            bit_cnt_r  <= 3'd0;
            serial_r   <= 1'b0;
          end else begin
            serial_r   <= 1'b1;
          end
        end
        START: begin
          if (baud_last_s) begin
            // The popped byte is valid in fifo_rd_s from the cycle after the pop;
            // shift_r keeps only the bits still to be sent.
            state_r    <= DATA;
            baud_cnt_r <= BAUD_ZERO;
            serial_r   <= fifo_rd_s[0];
            shift_r    <= {1'b1, fifo_rd_s[DATA_BITS-1:1]};
          end else begin
            baud_cnt_r <= baud_cnt_r + 1'b1;
            serial_r   <= 1'b0;
          end
        end
        DATA: begin
          if (baud_last_s) begin
            baud_cnt_r <= BAUD_ZERO;
            if (bit_cnt_r == LAST_BIT) begin
              state_r    <= STOP;
              serial_r   <= 1'b1;
              stop_idx_r <= 1'b0;
            end else begin
              bit_cnt_r  <= bit_cnt_r + 3'd1;
              serial_r   <= shift_r[0];
              shift_r    <= {1'b1, shift_r[DATA_BITS-1:1]};
            end
          end else begin
            baud_cnt_r <= baud_cnt_r + 1'b1;
          end
        end
        STOP: begin
          if (baud_last_s) begin
            baud_cnt_r <= BAUD_ZERO;
            stop_idx_r <= ~stop_idx_r;
            if (stop_last_s && pop_s) begin
              state_r   <= START;
              bit_cnt_r <= 3'd0;
              serial_r  <= 1'b0;
            end else if (stop_last_s) begin
              state_r   <= IDLE;
              serial_r  <= 1'b1;
            end else begin
              serial_r  <= 1'b1;
            end
          end else begin
            baud_cnt_r <= baud_cnt_r + 1'b1;
            serial_r   <= 1'b1;
          end
        end
        default: begin
          state_r  <= IDLE;
          serial_r <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: three instances (10 clk/bit, 2 clk/bit, 2 clk/bit with
// two stop bits) share one stimulus stream and are each compared every cycle against
// a queue-based line model; instance 0 is also decoded as a UART receiver would.
module tb_uart_transmitter;
  import uart_pkg::*;

  localparam int N     = 3;
  localparam int DEPTH = 4;

  function automatic int cpb_of(input int d);
    return (d == 0) ? 10 : 2;
  endfunction

  function automatic int stop_of(input int d);
    return (d == 2) ? 2 : 1;
  endfunction

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] data_in_s = 8'h00;
  logic       data_valid_s = 1'b0;

  always #5 clock = ~clock;

  logic       ser_w  [N];
  logic       busy_w [N];
  logic       rdy_w  [N];
  logic [2:0] cnt_w  [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    uart_transmitter_if ifc ();
    assign ifc.data_in    = data_in_s;
    assign ifc.data_valid = data_valid_s;
    assign rdy_w[g]       = ifc.data_ready;

    uart_transmitter #(
      .CLKS_PER_BIT ((g == 0) ? 10 : 2),
      .FIFO_DEPTH   (DEPTH),
      .STOP_BITS    ((g == 2) ? 2 : 1)
    ) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .tx_if      (ifc.slave),
      .serialOut  (ser_w[g]),
      .busy       (busy_w[g]),
      .fifo_count (cnt_w[g])
    );
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: bytes queue + per-cycle line schedule ----------------
  bit         sched   [N][$];
  logic [7:0] fq      [N][$];
  bit         inframe [N];
  bit         exp_ser [N] = '{1'b1, 1'b1, 1'b1};
  logic [7:0] exp0    [$];
  bit         last_acc0 = 1'b0;
  int         nacc0 = 0;
  bit         m_rdy;
  logic [7:0] m_b;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int d = 0; d < N; d++) begin
        sched[d].delete();
        fq[d].delete();
        inframe[d] = 1'b0;
        exp_ser[d] = 1'b1;
      end
      exp0.delete();
      last_acc0 = 1'b0;
    end else begin
      for (int d = 0; d < N; d++) begin
        m_rdy = (fq[d].size() < DEPTH);
        if (sched[d].size() == 0 && fq[d].size() > 0) begin
          m_b = fq[d].pop_front();
          for (int i = 0; i < 9 + stop_of(d); i++) begin
            for (int j = 0; j < cpb_of(d); j++) begin
              if (i == 0)      sched[d].push_back(1'b0);
              else if (i <= 8) sched[d].push_back(m_b[i-1]);
              else             sched[d].push_back(1'b1);
            end
          end
        end
        if (sched[d].size() > 0) begin
          inframe[d] = 1'b1;
          exp_ser[d] = sched[d].pop_front();
        end else begin
          inframe[d] = 1'b0;
          exp_ser[d] = 1'b1;
        end
        if (data_valid_s && m_rdy) begin
          fq[d].push_back(data_in_s);
          if (d == 0) begin
            exp0.push_back(data_in_s);
            nacc0++;
          end
        end
        if (d == 0) last_acc0 = data_valid_s && m_rdy;
      end
    end
  end

  always @(negedge clock) begin
    for (int d = 0; d < N; d++) begin
      chk($sformatf("serialOut[%0d]", d), ser_w[d], exp_ser[d]);
      chk($sformatf("busy[%0d]", d), busy_w[d], inframe[d] || (fq[d].size() != 0));
      chk($sformatf("fifo_count[%0d]", d), cnt_w[d], fq[d].size());
      chk($sformatf("data_ready[%0d]", d), rdy_w[d], fq[d].size() < DEPTH);
    end
  end

  // ---------------- receiver-style decoder on instance 0 ----------------
  int         cyc_n = 0;
  bit         rx_on = 1'b0;
  int         rx_k = 0;
  logic [7:0] rx_b = 8'h00;
  int         starts [$];

  always @(negedge clock) begin
    cyc_n++;
    if (!reset_n) begin
      rx_on = 1'b0;
    end else if (!rx_on) begin
      if (ser_w[0] == 1'b0) begin
        rx_on = 1'b1;
        rx_k  = 0;
        starts.push_back(cyc_n);
      end
    end else begin
      rx_k++;
      if (rx_k == 5) chk("rx start bit", ser_w[0], 0);
      if (rx_k % 10 == 5 && rx_k >= 15 && rx_k <= 85) rx_b[rx_k/10 - 1] = ser_w[0];
      if (rx_k == 95) chk("rx stop bit", ser_w[0], 1);
      if (rx_k == 99) begin
        rx_on = 1'b0;
        chk("rx byte", rx_b, (exp0.size() != 0) ? 32'(exp0.pop_front()) : 32'hFFFF_FFFF);
      end
    end
  end

  task automatic send0(input logic [7:0] b);
    bit got;
    got          = 1'b0;
    data_in_s    = b;
    data_valid_s = 1'b1;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(posedge clock);
      #1;
      got = last_acc0;
    end
    data_valid_s = 1'b0;
    data_in_s    = ~b;
    if (!got) chk("send accept", got, 1);
  endtask

  typedef struct {
    int         k;
    logic       ser;
    logic       bsy;
    logic [2:0] cnt;
  } vec_t;

  vec_t       tbl [18];
  int         cur;
  int         len  [N];
  bit         strt [N];
  bit         done [N];
  int         lows;
  int         acc_base;
  logic [7:0] burst [6];

  initial begin
    // sample k = clocks after the pop edge; A5 goes out LSB first as 1,0,1,0,0,1,0,1
    tbl = '{
      '{-1, 1'b1, 1'b1, 3'd1}, '{0, 1'b0, 1'b1, 3'd0}, '{9, 1'b0, 1'b1, 3'd0},
      '{10, 1'b1, 1'b1, 3'd0}, '{15, 1'b1, 1'b1, 3'd0}, '{25, 1'b0, 1'b1, 3'd0},
      '{35, 1'b1, 1'b1, 3'd0}, '{45, 1'b0, 1'b1, 3'd0}, '{55, 1'b0, 1'b1, 3'd0},
      '{65, 1'b1, 1'b1, 3'd0}, '{75, 1'b0, 1'b1, 3'd0}, '{79, 1'b0, 1'b1, 3'd0},
      '{80, 1'b1, 1'b1, 3'd0}, '{85, 1'b1, 1'b1, 3'd0}, '{90, 1'b1, 1'b1, 3'd0},
      '{95, 1'b1, 1'b1, 3'd0}, '{99, 1'b1, 1'b1, 3'd0}, '{100, 1'b1, 1'b0, 3'd0}
    };
    burst = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

    // reset state
    repeat (3) @(negedge clock);
    for (int d = 0; d < N; d++) begin
      chk("reset serialOut", ser_w[d], 1);
      chk("reset busy", busy_w[d], 0);
      chk("reset data_ready", rdy_w[d], 1);
      chk("reset fifo_count", cnt_w[d], 0);
    end
    #1 reset_n = 1'b1;
    repeat (20) @(negedge clock);
    chk("idle after release", ser_w[0], 1);

    // single byte A5 against the table
    send0(8'hA5);
    cur = -2;
    for (int v = 0; v < 18; v++) begin
      while (cur < tbl[v].k) begin
        @(negedge clock);
        cur++;
      end
      chk($sformatf("A5 serial k=%0d", tbl[v].k), ser_w[0], tbl[v].ser);
      chk($sformatf("A5 busy k=%0d", tbl[v].k), busy_w[0], tbl[v].bsy);
      chk($sformatf("A5 count k=%0d", tbl[v].k), cnt_w[0], tbl[v].cnt);
    end
    repeat (10) @(negedge clock);

    // frame length per instance: 100, 20 and 22 clocks
    send0(8'h5A);
    for (int d = 0; d < N; d++) begin
      len[d] = 0; strt[d] = 1'b0; done[d] = 1'b0;
    end
    for (int c = 0; c < 130; c++) begin
      @(negedge clock);
      for (int d = 0; d < N; d++) begin
        if (!strt[d] && ser_w[d] == 1'b0) strt[d] = 1'b1;
        if (strt[d] && !done[d]) begin
          if (busy_w[d]) len[d]++;
          else done[d] = 1'b1;
        end
      end
    end
    for (int d = 0; d < N; d++) begin
      chk($sformatf("frame length[%0d]", d), len[d], (9 + stop_of(d)) * cpb_of(d));
    end

    // push lands on the very edge where STOP ends with an empty FIFO
    send0(8'h81);
    repeat (100) @(posedge clock);
    #1;
    data_in_s    = 8'h7E;
    data_valid_s = 1'b1;
    @(posedge clock);
    #1 data_valid_s = 1'b0;
    @(negedge clock);
    chk("edge idle gap serial", ser_w[0], 1);
    chk("edge idle gap count", cnt_w[0], 1);
    @(negedge clock);
    chk("edge start after gap", ser_w[0], 0);
    repeat (120) @(negedge clock);

    // burst of six into a four-deep FIFO: zero-gap frames in order
    starts.delete();
    for (int i = 0; i < 6; i++) begin
      send0(burst[i]);
      if (i == 4) begin
        chk("burst full count", cnt_w[0], 4);
        chk("burst full ready", rdy_w[0], 0);
      end
    end
    repeat (700) @(negedge clock);
    chk("burst frame count", starts.size(), 6);
    for (int i = 1; i < 6 && i < starts.size(); i++) begin
      chk($sformatf("burst spacing %0d", i), starts[i] - starts[i-1], 100);
    end

    // reset during data bit 3 of 3C with two more bytes queued
    send0(8'h3C);
    send0(8'h99);
    send0(8'h42);
    repeat (43) @(posedge clock);
    #1;
    chk("pre-reset busy", busy_w[0], 1);
    chk("pre-reset count", cnt_w[0], 2);
    #2 reset_n = 1'b0;
    #1;
    for (int d = 0; d < N; d++) begin
      chk("async reset serialOut", ser_w[d], 1);
      chk("async reset busy", busy_w[d], 0);
      chk("async reset count", cnt_w[d], 0);
      chk("async reset ready", rdy_w[d], 1);
    end
    repeat (3) @(negedge clock);
    #1 reset_n = 1'b1;
    lows = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clock);
      if (ser_w[0] == 1'b0) lows++;
    end
    chk("no frame after reset", lows, 0);

    // random traffic until 256 bytes are accepted by instance 0
    acc_base = nacc0;
    for (int c = 0; c < 60000 && (nacc0 - acc_base) < 256; c++) begin
      @(posedge clock);
      #1;
      data_in_s    = 8'($urandom);
      data_valid_s = ((c % 4000) < 3000) && ($urandom_range(0, 15) == 0);
    end
    data_valid_s = 1'b0;
    chk("random accepted", (nacc0 - acc_base) >= 256, 1);
    repeat (800) @(negedge clock);
    chk("random drained", exp0.size(), 0);
    chk("random idle", busy_w[0], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
